// File: rtl/instruction_memory_sync.sv
// ============================================================================
// instruction_memory_sync
// ----------------------------------------------------------------------------
// Synchronous instruction memory for the pipelined RISC-V IF stage. The
// storage is little-endian and byte-addressed. The read path is registered,
// so an accepted fetch shows up one cycle later. The block also has
// hazard-unit stall/flush control, a byte-enabled loader write port for
// program download, misalignment and out-of-range fault detection, and a
// counter of accepted fetches.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (memory contents are kept)
//   fetch_req    request a fetch of Inst_Address this cycle
//   Inst_Address byte address of the instruction to fetch
//   stall        hold all fetch outputs and ignore fetch_req
//   flush        kill the output instruction (overrides stall)
//   Instruction  registered fetched instruction (NOP_INST when not valid)
//   inst_valid   Instruction is a real fetch result
//   inst_fault   the fetch behind Instruction was misaligned or out of range
//   load_en      loader word write strobe (takes priority over fetch)
//   load_addr    loader byte address; bits [1:0] are ignored
//   load_data    loader write data, little-endian
//   load_be      loader byte enables, bit i -> load_data[8i+7:8i]
//   fetch_count  number of accepted fetches, wraps modulo 2^32
// ============================================================================
module instruction_memory_sync #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter logic [31:0] NOP_INST    = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] Inst_Address,
    input  logic                  stall,
    input  logic                  flush,
    output logic [31:0]           Instruction,
    output logic                  inst_valid,
    output logic                  inst_fault,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    input  logic [3:0]            load_be,
    output logic [31:0]           fetch_count
);

    localparam int unsigned BW = $clog2(DEPTH_BYTES);

    // Highest word-aligned address whose four bytes all fit in the array.
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH_BYTES - 4);
    // A loader word is in range iff its aligned base is <= LAST_WORD. Because
    // LAST_WORD is aligned, that is the same as the raw address being
    // <= LAST_WORD + 3, which avoids clearing the low bits first.
    localparam logic [ADDR_WIDTH-1:0] LAST_BYTE = ADDR_WIDTH'(DEPTH_BYTES - 1);

    logic [7:0] mem [DEPTH_BYTES] = '{default: '0};

    logic        fetch_fault;
    logic [31:0] fetch_word;
    logic        load_in_range;

    // Full-width unsigned compare, so high address bits can never alias
    // into the array.
    assign fetch_fault   = (Inst_Address[1:0] != 2'b00) || (Inst_Address > LAST_WORD);
    assign load_in_range = (load_addr <= LAST_BYTE);

    // Combinational word assembly. The array is only indexed when the
    // address is known to be in range.
    always_comb begin
        fetch_word = NOP_INST;
        if (!fetch_fault) begin
            for (int unsigned k = 0; k < 4; k++) begin
                fetch_word[8*k +: 8] = mem[Inst_Address[BW-1:0] + BW'(k)];
            end
        end
    end

    // Loader write port. It is independent of stall/flush and is gated only
    // by reset.
    always_ff @(posedge clk) begin
        if (reset && load_en && load_in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (load_be[i]) begin
                    mem[{load_addr[BW-1:2], 2'b00} + BW'(i)] <= load_data[8*i +: 8];
                end
            end
        end
    end

    // Output register: flush > stall > loader > fetch > idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Instruction <= NOP_INST;
            inst_valid  <= 1'b0;
            inst_fault  <= 1'b0;
            fetch_count <= '0;
        end else if (flush) begin
            Instruction <= NOP_INST;
            inst_valid  <= 1'b0;
            inst_fault  <= 1'b0;
        end else if (stall) begin
            // hold every fetch output and the counter
        end else if (load_en) begin
            Instruction <= NOP_INST;
            inst_valid  <= 1'b0;
            inst_fault  <= 1'b0;
        end else if (fetch_req) begin
            Instruction <= fetch_word;
            inst_valid  <= 1'b1;
            inst_fault  <= fetch_fault;
            fetch_count <= fetch_count + 32'd1;
        end else begin
            Instruction <= NOP_INST;
            inst_valid  <= 1'b0;
            inst_fault  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_memory_sync.sv
// ============================================================================
// tb_instruction_memory_sync
// ----------------------------------------------------------------------------
// Directed testbench for instruction_memory_sync (DEPTH_BYTES=1024,
// ADDR_WIDTH=64). A byte-array reference model tracks the expected outputs.
// Every falling edge compares the DUT against that model, and hand-computed
// literals pin the key results.
// ============================================================================
module tb_instruction_memory_sync;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [63:0] Inst_Address = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] Instruction;
    logic        inst_valid;
    logic        inst_fault;
    logic        load_en = 1'b0;
    logic [63:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic [3:0]  load_be = '0;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    instruction_memory_sync #(
        .DEPTH_BYTES(1024),
        .ADDR_WIDTH (64),
        .NOP_INST   (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .Inst_Address(Inst_Address),
        .stall       (stall),
        .flush       (flush),
        .Instruction (Instruction),
        .inst_valid  (inst_valid),
        .inst_fault  (inst_fault),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_be     (load_be),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mm [1024] = '{default: 8'h00};
    logic [31:0] exp_inst  = NOP;
    logic        exp_valid = 1'b0;
    logic        exp_fault = 1'b0;
    logic [31:0] m_count   = '0;

    always @(posedge clk or negedge reset) begin
        longint unsigned a;
        longint unsigned wa;
        if (!reset) begin
            exp_inst = NOP; exp_valid = 1'b0; exp_fault = 1'b0; m_count = '0;
        end else begin
            a = Inst_Address;
            if (flush || (!stall && (load_en || !fetch_req))) begin
                exp_inst = NOP; exp_valid = 1'b0; exp_fault = 1'b0;
            end else if (!stall) begin
                exp_valid = 1'b1;
                m_count   = m_count + 1;
                if ((a % 4) != 0 || a > 1020) begin
                    exp_inst = NOP; exp_fault = 1'b1;
                end else begin
                    exp_inst = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
                    exp_fault = 1'b0;
                end
            end
            if (load_en) begin
                wa = load_addr - (load_addr % 4);
                if (wa <= 1020)
                    for (int b = 0; b < 4; b++)
                        if (load_be[b]) mm[wa + longint'(b)] = load_data[8*b +: 8];
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        chk("model_inst",  {32'd0, Instruction}, {32'd0, exp_inst});
        chk("model_valid", {63'd0, inst_valid},  {63'd0, exp_valid});
        chk("model_fault", {63'd0, inst_fault},  {63'd0, exp_fault});
        chk("model_count", {32'd0, fetch_count}, {32'd0, m_count});
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic fr, input logic [63:0] fa,
                         input logic ld, input logic [63:0] la, input logic [31:0] ldat,
                         input logic [3:0] be, input logic st, input logic fl);
        fetch_req = fr; Inst_Address = fa;
        load_en = ld; load_addr = la; load_data = ldat; load_be = be;
        stall = st; flush = fl;
        @(negedge clk);
    endtask

    task automatic fetch(input logic [63:0] fa);
        drive(1'b1, fa, 1'b0, 64'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [63:0] la, input logic [31:0] d, input logic [3:0] be);
        drive(1'b0, 64'd0, 1'b1, la, d, be, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 64'd0, 1'b0, 64'd0, 32'd0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic lit(input string tag, input logic [31:0] i, input logic v,
                       input logic f, input logic [31:0] c);
        chk({tag, "_inst"},  {32'd0, Instruction}, {32'd0, i});
        chk({tag, "_valid"}, {63'd0, inst_valid},  {63'd0, v});
        chk({tag, "_fault"}, {63'd0, inst_fault},  {63'd0, f});
        chk({tag, "_count"}, {32'd0, fetch_count}, {32'd0, c});
    endtask

    initial begin
        #1 reset = 1'b0;
        #1 lit("por", NOP, 1'b0, 1'b0, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Load then fetch
        load(64'h0, 32'h00500513, 4'hF);
        load(64'h4, 32'h005505b3, 4'hF);
        lit("load", NOP, 1'b0, 1'b0, 32'd0);
        fetch(64'h0);
        lit("f0", 32'h00500513, 1'b1, 1'b0, 32'd1);
        fetch(64'h4);
        lit("f4", 32'h005505b3, 1'b1, 1'b0, 32'd2);

        // Byte enables
        load(64'h8, 32'h11223344, 4'hF);
        load(64'h8, 32'hAABBCCDD, 4'b0101);
        fetch(64'h8);
        lit("be", 32'h11BB33DD, 1'b1, 1'b0, 32'd3);

        // Faults
        fetch(64'h6);
        lit("mis", NOP, 1'b1, 1'b1, 32'd4);
        fetch(64'h3FE);
        lit("oor", NOP, 1'b1, 1'b1, 32'd5);
        fetch(64'h3FC);
        lit("last", 32'h0, 1'b1, 1'b0, 32'd6);
        fetch(64'h1_0000_0000);
        lit("high", NOP, 1'b1, 1'b1, 32'd7);
        fetch(64'h400);
        lit("edge", NOP, 1'b1, 1'b1, 32'd8);

        // Stall / flush
        fetch(64'h0);
        lit("pre", 32'h00500513, 1'b1, 1'b0, 32'd9);
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 64'h4, 1'b0, 64'd0, 32'd0, 4'h0, 1'b1, 1'b0);
            lit("stall", 32'h00500513, 1'b1, 1'b0, 32'd9);
        end
        drive(1'b1, 64'h4, 1'b0, 64'd0, 32'd0, 4'h0, 1'b1, 1'b1);
        lit("stflush", NOP, 1'b0, 1'b0, 32'd9);
        // Stall release: this fetch is evaluated on the releasing edge
        fetch(64'h4);
        lit("release", 32'h005505b3, 1'b1, 1'b0, 32'd10);
        // Loader still writes during stall
        drive(1'b0, 64'd0, 1'b1, 64'hC, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
        lit("ldstall", 32'h005505b3, 1'b1, 1'b0, 32'd10);
        fetch(64'hC);
        lit("raw_st", 32'hDEADBEEF, 1'b1, 1'b0, 32'd11);
        // Flush drops a same-cycle fetch
        drive(1'b1, 64'h0, 1'b0, 64'd0, 32'd0, 4'h0, 1'b0, 1'b1);
        lit("flush", NOP, 1'b0, 1'b0, 32'd11);

        // Load collision, then read-after-write
        drive(1'b1, 64'h0, 1'b1, 64'h13, 32'h12345678, 4'hF, 1'b0, 1'b0);
        lit("collide", NOP, 1'b0, 1'b0, 32'd11);
        fetch(64'h10);
        lit("raw", 32'h12345678, 1'b1, 1'b0, 32'd12);

        // Out-of-range load is dropped, not wrapped
        load(64'h400, 32'hFFFFFFFF, 4'hF);
        load(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFFFFFF, 4'hF);
        fetch(64'h0);
        lit("nowrap", 32'h00500513, 1'b1, 1'b0, 32'd13);

        // Counter wrap via force shortcut
        idle();
        #1 force dut.fetch_count = 32'hFFFFFFFF;
        m_count = 32'hFFFFFFFF;
        #1 release dut.fetch_count;
        idle();
        lit("preset", NOP, 1'b0, 1'b0, 32'hFFFFFFFF);
        fetch(64'h4);
        lit("wrap", 32'h005505b3, 1'b1, 1'b0, 32'd0);

        // Asynchronous reset mid-stream; memory survives
        fetch(64'h8);
        lit("prerst", 32'h11BB33DD, 1'b1, 1'b0, 32'd1);
        #2 reset = 1'b0;
        #1 lit("arst", NOP, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        fetch_req = 1'b0;
        reset = 1'b1;
        fetch(64'h0);
        lit("postrst", 32'h00500513, 1'b1, 1'b0, 32'd1);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
